// File: rtl/cordic_pkg.sv
// Shared types and constants for the single-step CORDIC micro-rotation block.
package cordic_pkg;

  typedef enum logic {
    MODE_HYPERBOLIC = 1'b0,
    MODE_CIRCULAR   = 1'b1
  } mode_e;

  localparam int CORDIC_WIDTH_DEF = 32;

  // Binary angle: full scale +/-1 maps to +/-180 degrees.
  localparam logic [31:0] ANGLE_45 = 32'h2000_0000;

endpackage

// File: rtl/cordic_ashr.sv
// Arithmetic (sign-filling) logarithmic barrel shifter.
module cordic_ashr #(
  parameter int p_WIDTH = 32,
  parameter int p_SHW   = $clog2(p_WIDTH)
) (
  input  logic signed [p_WIDTH-1:0] i_data,
  input  logic        [p_SHW-1:0]   i_shamt,
  output logic signed [p_WIDTH-1:0] o_data
);

  logic signed [p_WIDTH-1:0] w_acc;

  // One stage per shift-amount bit; stage k shifts by 2^k.
  always_comb begin
    w_acc = i_data;
    for (int k = 0; k < p_SHW; k++) begin
      if (i_shamt[k]) w_acc = w_acc >>> (2 ** k);
    end
  end

  assign o_data = w_acc;

endmodule

// File: rtl/cordic.sv
// One registered CORDIC micro-rotation (circular or hyperbolic), latency 1.
// Optional x/y saturation: define CORDIC_SAT_EN.
module cordic
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = CORDIC_WIDTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic signed [p_WIDTH-1:0]    i_xprev,
  input  logic signed [p_WIDTH-1:0]    i_yprev,
  input  logic signed [p_WIDTH-1:0]    i_zprev,
  input  logic                         i_dprev,
  input  logic                         i_mode,
  input  logic signed [p_WIDTH-1:0]    i_lut,
  input  logic [$clog2(p_WIDTH)-1:0]   i_shift_amnt,
  output logic signed [p_WIDTH-1:0]    o_xnext,
  output logic signed [p_WIDTH-1:0]    o_ynext,
  output logic signed [p_WIDTH-1:0]    o_znext,
  output logic                         o_valid
);

  logic signed [p_WIDTH-1:0] w_xs, w_ys;
  logic signed [p_WIDTH-1:0] w_xnext, w_ynext, w_znext;
  logic                      w_circ, w_x_sub, w_y_sub, w_z_sub;

  logic signed [p_WIDTH-1:0] r_x, r_y, r_z;
  logic                      r_valid;

  cordic_ashr #(.p_WIDTH(p_WIDTH)) u_ashr_x (
    .i_data  (i_xprev),
    .i_shamt (i_shift_amnt),
    .o_data  (w_xs)
  );

  cordic_ashr #(.p_WIDTH(p_WIDTH)) u_ashr_y (
    .i_data  (i_yprev),
    .i_shamt (i_shift_amnt),
    .o_data  (w_ys)
  );

  // y and z follow d alone; x flips sense between circular and hyperbolic.
  assign w_circ  = (mode_e'(i_mode) == MODE_CIRCULAR);
  assign w_x_sub = w_circ ? i_dprev : ~i_dprev;
  assign w_y_sub = ~i_dprev;
  assign w_z_sub = i_dprev;

  // z is an angle and always wraps.
  assign w_znext = w_z_sub ? (i_zprev - i_lut) : (i_zprev + i_lut);

`ifdef CORDIC_SAT_EN
  localparam logic [p_WIDTH-1:0] lp_MAX = {1'b0, {(p_WIDTH-1){1'b1}}};
  localparam logic [p_WIDTH-1:0] lp_MIN = {1'b1, {(p_WIDTH-1){1'b0}}};

  logic [p_WIDTH:0] w_xw, w_yw;

  function automatic logic [p_WIDTH-1:0] f_clamp(input logic [p_WIDTH:0] v);
    if (v[p_WIDTH] == v[p_WIDTH-1]) return v[p_WIDTH-1:0];
    return v[p_WIDTH] ? lp_MIN : lp_MAX;
  endfunction

  // One guard bit exposes overflow of the signed add/sub.
  assign w_xw = w_x_sub ? ({i_xprev[p_WIDTH-1], i_xprev} - {w_ys[p_WIDTH-1], w_ys})
                        : ({i_xprev[p_WIDTH-1], i_xprev} + {w_ys[p_WIDTH-1], w_ys});
  assign w_yw = w_y_sub ? ({i_yprev[p_WIDTH-1], i_yprev} - {w_xs[p_WIDTH-1], w_xs})
                        : ({i_yprev[p_WIDTH-1], i_yprev} + {w_xs[p_WIDTH-1], w_xs});
  assign w_xnext = f_clamp(w_xw);
  assign w_ynext = f_clamp(w_yw);
`else
  assign w_xnext = w_x_sub ? (i_xprev - w_ys) : (i_xprev + w_ys);
  assign w_ynext = w_y_sub ? (i_yprev - w_xs) : (i_yprev + w_xs);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_x <= w_xnext;
        r_y <= w_ynext;
        r_z <= w_znext;
      end
    end
  end

  assign o_xnext = r_x;
  assign o_ynext = r_y;
  assign o_znext = r_z;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: directed vectors, randomized model check, feedback loop, reset.
module tb_cordic;
  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        rst, vld, d, mode;
  logic [31:0] x, y, z, lut;
  logic [4:0]  sh;
  logic [31:0] ox, oy, oz;
  logic        ov;

  int checks = 0;
  int errors = 0;

  // Model state: what the registered outputs must hold.
  logic [31:0] ex = 0, ey = 0, ez = 0;
  logic        ev = 0;

  always #5 clk = ~clk;

  cordic #(.p_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld),
    .i_xprev(x), .i_yprev(y), .i_zprev(z), .i_dprev(d), .i_mode(mode),
    .i_lut(lut), .i_shift_amnt(sh),
    .o_xnext(ox), .o_ynext(oy), .o_znext(oz), .o_valid(ov)
  );

  // floor(a / 2^i): the mathematical meaning of an arithmetic right shift
  function automatic longint fdiv(input longint a, input int i);
    longint p, q;
    p = longint'(1) << i;
    q = a / p;
    if ((a % p) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] fit(input longint v);
`ifdef CORDIC_SAT_EN
    if (v > longint'(32'h7FFF_FFFF)) return 32'h7FFF_FFFF;
    if (v < -longint'(32'h8000_0000)) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  // x' = x - m*s*y/2^i ; y' = y + s*x/2^i ; z' = z - s*lut ; m=+1 circ, -1 hyp ; s=+1 for d=1
  task automatic model(input logic [31:0] xi, yi, zi, li, input int i, input bit di, input bit ci,
                       output logic [31:0] xo, yo, zo);
    longint sx, sy, sz, sl, s, m;
    sx = longint'($signed(xi)); sy = longint'($signed(yi));
    sz = longint'($signed(zi)); sl = longint'($signed(li));
    s  = di ? 1 : -1;
    m  = ci ? 1 : -1;
    xo = fit(sx - m * s * fdiv(sy, i));
    yo = fit(sy + s * fdiv(sx, i));
    zo = 32'(sz - s * sl);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply(input logic [31:0] xi, yi, zi, li, input int i, input bit di, input bit ci);
    vld = 1'b1; x = xi; y = yi; z = zi; lut = li; sh = 5'(i); d = di; mode = ci;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b1; x = 32'h1234_5678; y = 32'h1; z = 32'h2; lut = 32'h3;
    sh = 0; d = 1; mode = 1;
    tick(); tick();
    checks++; if (ox !== 0) begin errors++; $display("FAIL reset_x got %h want 0", ox); end
    checks++; if (oy !== 0) begin errors++; $display("FAIL reset_y got %h want 0", oy); end
    checks++; if (oz !== 0) begin errors++; $display("FAIL reset_z got %h want 0", oz); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL reset_valid got %b want 0", ov); end
    rst = 1'b0; vld = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] yexp;
    apply(32'h4DBA76D4, 32'h0, 32'h071C71C7, ANGLE_45, 0, 1, 1);
    checks++; if (ox !== 32'h4DBA76D4) begin errors++; $display("FAIL v1_x got %h want 4dba76d4", ox); end
    checks++; if (oy !== 32'h4DBA76D4) begin errors++; $display("FAIL v1_y got %h want 4dba76d4", oy); end
    checks++; if (oz !== 32'hE71C71C7) begin errors++; $display("FAIL v1_z got %h want e71c71c7", oz); end
    checks++; if (ov !== 1'b1)         begin errors++; $display("FAIL v1_valid got %b want 1", ov); end
    apply(32'h40000000, 32'h20000000, 32'hF0000000, 32'h12E4051D, 1, 0, 1);
    checks++; if (ox !== 32'h50000000) begin errors++; $display("FAIL v2_x got %h want 50000000", ox); end
    checks++; if (oy !== 32'h00000000) begin errors++; $display("FAIL v2_y got %h want 00000000", oy); end
    checks++; if (oz !== 32'h02E4051D) begin errors++; $display("FAIL v2_z got %h want 02e4051d", oz); end
    apply(32'h10000000, 32'hF0000000, 32'h0, 32'h051EA6FC, 2, 1, 0);
    checks++; if (ox !== 32'h0C000000) begin errors++; $display("FAIL v3_x got %h want 0c000000", ox); end
    checks++; if (oy !== 32'hF4000000) begin errors++; $display("FAIL v3_y got %h want f4000000", oy); end
    checks++; if (oz !== 32'hFAE15904) begin errors++; $display("FAIL v3_z got %h want fae15904", oz); end
`ifdef CORDIC_SAT_EN
    yexp = 32'h7FFFFFFF;
`else
    yexp = 32'hBFFFFFFF;
`endif
    apply(32'h40000000, 32'h7FFFFFFF, 32'h0, 32'h0, 0, 1, 1);
    checks++; if (oy !== yexp) begin errors++; $display("FAIL v4_yovf got %h want %h", oy, yexp); end
    // negative operand shifted the full width becomes all ones
    apply(32'h80000000, 32'h0, 32'h0, 32'h0, 31, 1, 1);
    checks++; if (oy !== 32'hFFFFFFFF) begin errors++; $display("FAIL v5_shift31 got %h want ffffffff", oy); end
    // output holds when idle
    vld = 1'b0; x = 32'h5555_5555; tick();
    checks++; if (oy !== 32'hFFFFFFFF) begin errors++; $display("FAIL hold_y got %h want ffffffff", oy); end
    checks++; if (ov !== 1'b0)         begin errors++; $display("FAIL hold_valid got %b want 0", ov); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xi, yi, zi, li, nx, ny, nz;
    int i; bit di, ci, vi;
    rst = 1'b1; vld = 1'b0; tick(); rst = 1'b0;
    ex = 0; ey = 0; ez = 0; ev = 0;
    for (int n = 0; n < 300; n++) begin
      xi = $urandom; yi = $urandom; zi = $urandom; li = $urandom;
      case ($urandom_range(0, 7))
        0: xi = 32'h8000_0000;
        1: yi = 32'h7FFF_FFFF;
        2: begin xi = 32'h7FFF_FFFF; yi = 32'h8000_0000; end
        default: ;
      endcase
      i = $urandom_range(0, 31); di = 1'($urandom); ci = 1'($urandom);
      vi = ($urandom_range(0, 3) != 0);
      vld = vi; x = xi; y = yi; z = zi; lut = li; sh = 5'(i); d = di; mode = ci;
      model(xi, yi, zi, li, i, di, ci, nx, ny, nz);
      if (vi) begin ex = nx; ey = ny; ez = nz; end
      ev = vi;
      tick();
      checks++; if (ox !== ex) begin errors++; $display("FAIL rnd%0d_x got %h want %h", n, ox, ex); end
      checks++; if (oy !== ey) begin errors++; $display("FAIL rnd%0d_y got %h want %h", n, oy, ey); end
      checks++; if (oz !== ez) begin errors++; $display("FAIL rnd%0d_z got %h want %h", n, oz, ez); end
      checks++; if (ov !== ev) begin errors++; $display("FAIL rnd%0d_valid got %b want %b", n, ov, ev); end
    end
    vld = 1'b0;
  endtask

  task automatic test_rotation_loop();
    real pi, scale;
    longint tx, ty, ax, ay, az;
    logic [31:0] cx, cy, cz;
    pi = 3.14159265358979323846;
    scale = 2147483648.0;
    cx = 32'h4DBA76D4; cy = 32'h0; cz = 32'h071C71C7;
    for (int i = 0; i < 20; i++) begin
      apply(cx, cy, cz, 32'($rtoi($atan(1.0 / (2.0 ** i)) / pi * scale + 0.5)), i, ~cz[31], 1);
      cx = ox; cy = oy; cz = oz;
    end
    tx = longint'($rtoi($cos(10.0 * pi / 180.0) * scale));
    ty = longint'($rtoi($sin(10.0 * pi / 180.0) * scale));
    ax = longint'($signed(cx)) - tx; if (ax < 0) ax = -ax;
    ay = longint'($signed(cy)) - ty; if (ay < 0) ay = -ay;
    az = longint'($signed(cz));      if (az < 0) az = -az;
    checks++; if (ax > 32768) begin errors++; $display("FAIL loop_cos got %h want %h", cx, 32'(tx)); end
    checks++; if (ay > 32768) begin errors++; $display("FAIL loop_sin got %h want %h", cy, 32'(ty)); end
    checks++; if (az > 32768) begin errors++; $display("FAIL loop_z got %h want ~0", cz); end
    vld = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0444_4444, 3, 1, 1);
    rst = 1'b1; vld = 1'b1; x = 32'h7777_7777;
    tick();
    checks++; if (ox !== 0 || oy !== 0 || oz !== 0) begin errors++; $display("FAIL midrst_xyz got %h %h %h want 0", ox, oy, oz); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL midrst_valid got %b want 0", ov); end
    rst = 1'b0; vld = 1'b0; x = 32'h1234_0000; y = 32'h0000_4321;
    tick(); tick();
    checks++; if (ox !== 0 || oy !== 0 || oz !== 0) begin errors++; $display("FAIL postrst_hold got %h %h %h want 0", ox, oy, oz); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL postrst_valid got %b want 0", ov); end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; d = 0; mode = 0; x = 0; y = 0; z = 0; lut = 0; sh = 0;
    #2;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_rotation_loop();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
